// File: rtl/difftest_step_batcher.sv
// rtl/difftest_step_batcher.sv - batches DUT commit counts into endpoint steps with flush, timeout and exit drain
// Optional statistics counters: define DIFFTEST_STEP_BATCH_STATS_EN.
module difftest_step_batcher #(
  parameter int STEP_W  = 8,
  parameter int CNT_W   = 4,
  parameter int BATCH   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_commit_valid,
  input  logic [CNT_W-1:0]  in_commit_cnt,
  input  logic              in_flush,
  input  logic [63:0]       in_exit,
  output logic [STEP_W-1:0] out_step,
  output logic [63:0]       out_exit,
  output logic              out_busy
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  ,
  output logic [63:0]       stat_batches,
  output logic [63:0]       stat_timeouts
`endif
);

  localparam int ACC_W = STEP_W + 1;
  localparam logic [ACC_W-1:0] STEP_MAX = {1'b0, {STEP_W{1'b1}}};
  localparam logic [ACC_W-1:0] BATCH_V  = ACC_W'(BATCH);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [31:0]       timer_q, timer_d;
  logic [63:0]       exit_q, exit_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [ACC_W-1:0]  sum, src, emit_val;
  logic              exiting, hit_batch, hit_flush, hit_timeout, emit;

  assign sum      = acc_q + (in_commit_valid ? ACC_W'(in_commit_cnt) : '0);
  // DRAIN empties what is already held; the live inputs are ignored there
  assign src      = (state_q == S_DRAIN) ? acc_q : sum;
  assign emit_val = (src > STEP_MAX) ? STEP_MAX : src;

  assign exiting     = (in_exit != 64'd0);
  assign hit_batch   = (sum >= BATCH_V);
  assign hit_flush   = (in_flush || exiting) && (sum != '0);
  assign hit_timeout = TO_EN && (timer_q == TO_LAST) && (acc_q != '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    timer_d = timer_q;
    exit_d  = exit_q;
    step_d  = '0;
    emit    = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        emit = hit_batch || hit_flush || hit_timeout;
        if (emit) begin
          step_d  = emit_val[STEP_W-1:0];
          acc_d   = sum - emit_val;
          timer_d = '0;
        end else begin
          acc_d = sum;
          if (sum == '0)
            timer_d = '0;
          else if (state_q == S_ACCUM && timer_q != '1)
            timer_d = timer_q + 32'd1;
        end
        if (exiting) begin
          exit_d  = in_exit;
          state_d = S_DRAIN;
        end else begin
          state_d = (acc_d != '0) ? S_ACCUM : S_IDLE;
        end
      end
      S_DRAIN: begin
        timer_d = '0;
        if (acc_q == '0) begin
          state_d = S_DONE;
        end else begin
          emit   = 1'b1;
          step_d = emit_val[STEP_W-1:0];
          acc_d  = acc_q - emit_val;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      timer_q <= '0;
      exit_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      timer_q <= timer_d;
      exit_q  <= exit_d;
      step_q  <= step_d;
    end
  end

  assign out_step = step_q;
  assign out_exit = (state_q == S_DONE) ? exit_q : 64'd0;
  assign out_busy = (state_q == S_ACCUM) || (state_q == S_DRAIN);

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  logic [63:0] stat_batches_q, stat_batches_d;
  logic [63:0] stat_timeouts_q, stat_timeouts_d;
  logic        timeout_only;

  assign timeout_only = emit && hit_timeout && !hit_batch && !hit_flush &&
                        ((state_q == S_IDLE) || (state_q == S_ACCUM));

  always_comb begin
    stat_batches_d  = stat_batches_q;
    stat_timeouts_d = stat_timeouts_q;
    if (emit)
      stat_batches_d = stat_batches_q + 64'd1;
    if (timeout_only)
      stat_timeouts_d = stat_timeouts_q + 64'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_batches_q  <= '0;
      stat_timeouts_q <= '0;
    end else begin
      stat_batches_q  <= stat_batches_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign stat_batches  = stat_batches_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// tb/tb_difftest_step_batcher.sv - directed checks of difftest_step_batcher in two configurations
module tb_difftest_step_batcher;

  logic        clock;
  logic        reset;

  logic        va_a, flush_a;
  logic [3:0]  cnt_a;
  logic [63:0] exit_a;
  logic [7:0]  step_a;
  logic [63:0] oexit_a;
  logic        busy_a;

  logic        va_b, flush_b;
  logic [3:0]  cnt_b;
  logic [63:0] exit_b;
  logic [3:0]  step_b;
  logic [63:0] oexit_b;
  logic        busy_b;

`ifdef DIFFTEST_STEP_BATCH_STATS_EN
  logic [63:0] sb_a, st_a, sb_b, st_b;
`endif

  int checks = 0;
  int errors = 0;

  difftest_step_batcher #(.STEP_W(8), .CNT_W(4), .BATCH(32), .TIMEOUT(10)) u_a (
    .clock           (clock),
    .reset           (reset),
    .in_commit_valid (va_a),
    .in_commit_cnt   (cnt_a),
    .in_flush        (flush_a),
    .in_exit         (exit_a),
    .out_step        (step_a),
    .out_exit        (oexit_a),
    .out_busy        (busy_a)
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    ,
    .stat_batches    (sb_a),
    .stat_timeouts   (st_a)
`endif
  );

  difftest_step_batcher #(.STEP_W(4), .CNT_W(4), .BATCH(15), .TIMEOUT(0)) u_b (
    .clock           (clock),
    .reset           (reset),
    .in_commit_valid (va_b),
    .in_commit_cnt   (cnt_b),
    .in_flush        (flush_b),
    .in_exit         (exit_b),
    .out_step        (step_b),
    .out_exit        (oexit_b),
    .out_busy        (busy_b)
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    ,
    .stat_batches    (sb_b),
    .stat_timeouts   (st_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    va_a = 0; cnt_a = 0; flush_a = 0; exit_a = 0;
    va_b = 0; cnt_b = 0; flush_b = 0; exit_b = 0;
    tick;
    chk("rst_step_a", 64'(step_a), 64'd0);
    chk("rst_exit_a", oexit_a, 64'd0);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_step_b", 64'(step_b), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // threshold crossing: 8 x 4 reaches 32
    for (int i = 0; i < 8; i++) begin
      va_a = 1; cnt_a = 4;
      tick;
      if (i < 7) begin
        chk("thr_hold", 64'(step_a), 64'd0);
        chk("thr_busy", 64'(busy_a), 64'd1);
      end
    end
    chk("thr_step", 64'(step_a), 64'd32);
    chk("thr_idle", 64'(busy_a), 64'd0);
    va_a = 0;
    tick;
    chk("thr_once", 64'(step_a), 64'd0);

    // flush with nothing pending
    flush_a = 1;
    tick;
    chk("flush0_step", 64'(step_a), 64'd0);
    chk("flush0_idle", 64'(busy_a), 64'd0);
    flush_a = 0;

    // timeout after 10 cycles
    va_a = 1; cnt_a = 3;
    tick;
    va_a = 0;
    chk("to_busy", 64'(busy_a), 64'd1);
    for (int k = 1; k <= 10; k++) begin
      tick;
      if (k < 10) chk("to_wait", 64'(step_a), 64'd0);
    end
    chk("to_step", 64'(step_a), 64'd3);
    chk("to_idle", 64'(busy_a), 64'd0);
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    chk("to_stat_b", sb_a, 64'd2);
    chk("to_stat_t", st_a, 64'd1);
`endif

    // partial flush
    va_a = 1; cnt_a = 5;
    tick;
    va_a = 0; flush_a = 1;
    tick;
    chk("pflush_step", 64'(step_a), 64'd5);
    flush_a = 0;

    // threshold and flush together: one emission of 35
    va_a = 1; cnt_a = 15;
    tick;
    tick;
    chk("sim_hold", 64'(step_a), 64'd0);
    cnt_a = 5; flush_a = 1;
    tick;
    chk("sim_step", 64'(step_a), 64'd35);
    va_a = 0; flush_a = 0;
    tick;
    chk("sim_once", 64'(step_a), 64'd0);
    chk("sim_idle", 64'(busy_a), 64'd0);

    // exit with pending commits
    va_a = 1; cnt_a = 5;
    tick;
    cnt_a = 2; exit_a = 64'd1;
    tick;
    chk("exit_step", 64'(step_a), 64'd7);
    chk("exit_early", oexit_a, 64'd0);
    chk("exit_drain", 64'(busy_a), 64'd1);
    cnt_a = 9; exit_a = 64'd2;
    tick;
    chk("exit_ign", 64'(step_a), 64'd0);
    chk("exit_code", oexit_a, 64'd1);
    chk("exit_done", 64'(busy_a), 64'd0);
    tick;
    chk("exit_hold", oexit_a, 64'd1);
    chk("exit_nostep", 64'(step_a), 64'd0);
    va_a = 0; exit_a = 0;
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    chk("a_stat_b", sb_a, 64'd5);
    chk("a_stat_t", st_a, 64'd1);
`endif

    // saturation and carry on 4-bit step
    va_b = 1; cnt_b = 14;
    tick;
    chk("sat_hold", 64'(step_b), 64'd0);
    chk("sat_busy", 64'(busy_b), 64'd1);
    cnt_b = 15;
    tick;
    chk("sat_step", 64'(step_b), 64'd15);
    va_b = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("sat_notimeout", 64'(step_b), 64'd0);
    end
    flush_b = 1;
    tick;
    chk("sat_carry", 64'(step_b), 64'd14);
    chk("sat_idle", 64'(busy_b), 64'd0);
    flush_b = 0;

    // exit drain with saturation over two steps
    va_b = 1; cnt_b = 14;
    tick;
    cnt_b = 15; exit_b = 64'd3;
    tick;
    chk("drn_step1", 64'(step_b), 64'd15);
    chk("drn_busy", 64'(busy_b), 64'd1);
    exit_b = 64'd7;
    tick;
    chk("drn_step2", 64'(step_b), 64'd14);
    chk("drn_noexit", oexit_b, 64'd0);
    tick;
    chk("drn_done_step", 64'(step_b), 64'd0);
    chk("drn_code", oexit_b, 64'd3);
    chk("drn_idle", 64'(busy_b), 64'd0);
    va_b = 0; exit_b = 0;
`ifdef DIFFTEST_STEP_BATCH_STATS_EN
    chk("b_stat_b", sb_b, 64'd4);
    chk("b_stat_t", st_b, 64'd0);
`endif

    reset = 1'b1;
    #1;
    chk("rst2_exit", oexit_b, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // asynchronous reset while draining
    va_b = 1; cnt_b = 14;
    tick;
    cnt_b = 15; exit_b = 64'd5;
    tick;
    chk("ar_step", 64'(step_b), 64'd15);
    chk("ar_drain", 64'(busy_b), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_step0", 64'(step_b), 64'd0);
    chk("ar_exit0", oexit_b, 64'd0);
    chk("ar_busy0", 64'(busy_b), 64'd0);
    chk("ar_exit_a0", oexit_a, 64'd0);
    va_b = 0; exit_b = 0;
    #2;
    reset = 1'b0;
    tick;
    chk("ar_post_busy", 64'(busy_b), 64'd0);
    chk("ar_post_step", 64'(step_b), 64'd0);
    chk("ar_post_exit", oexit_b, 64'd0);
    va_b = 1; cnt_b = 15;
    tick;
    chk("ar_fresh", 64'(step_b), 64'd15);
    chk("ar_fresh_idle", 64'(busy_b), 64'd0);
    va_b = 0;
    tick;
    chk("ar_fresh_once", 64'(step_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
